mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one unified instruction/data memory port between the fetch unit and the load/store path.
- Allows the core to run with a single-ported memory behind a variable-latency ready handshake.
- Sits between the PC/fetch logic and the memory, on the same path as the decoder's memory_read/memory_write enables.
- Arbitrates round-robin, sequences each transfer through a small FSM, returns registered read data, times out hung accesses, and produces the core stall.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, max cycles waiting for mem_ready before abort (must be >=1).

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held high until if_valid
- if_addr  in  AW  fetch address (PC); stable while if_req is high
- if_valid  out  1  one-cycle pulse: fetch complete
- if_rdata  out  DW  fetched instruction; valid with if_valid
- d_rd  in  1  load request (memory_read); held until d_valid
- d_wr  in  1  store request (memory_write); held until d_valid
- d_addr  in  AW  load/store address (ALU result)
- d_wdata  in  DW  store data
- d_valid  out  1  one-cycle pulse: load/store complete
- d_rdata  out  DW  load data; valid with d_valid
- err  out  1  one-cycle pulse with if_valid/d_valid on timeout abort
- stall  out  1  hold PC/pipeline
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_ready  in  1  memory done; read data valid this cycle
- mem_rdata  in  DW  memory read data

Behaviour:
- Reset is asynchronous and active-low. It forces:
  - state=IDLE, last_grant=DATA, timer=0;
  - if_valid=0, d_valid=0, err=0;
  - if_rdata=0, d_rdata=0;
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- d_req = d_rd | d_wr. If both d_rd and d_wr are high, d_wr wins (store).
- FSM states: IDLE, GNT_I, GNT_D, RESP.
- IDLE, choosing a grant:
  - Only one request present: grant that requester.
  - Both present: grant the side opposite last_grant.
  - After reset, fetch therefore wins first.
  - On grant: move to GNT_I or GNT_D, update last_grant, register address/we/wdata into the mem_* outputs, clear timer.
- Requests are only sampled when the previous response has already been pulsed. A requester whose valid pulsed this cycle is not re-granted until the following IDLE.
- GNT_x:
  - mem_req=1 and mem_addr/mem_we/mem_wdata are held stable.
  - timer increments each cycle mem_ready=0.
  - mem_ready=1: capture mem_rdata into if_rdata or d_rdata (d_rdata captures on stores too), deassert mem_req next cycle, go to RESP.
  - timer reaches TIMEOUT-1 with mem_ready still 0: abort. Go to RESP with err flagged; rdata for that side is forced to 0.
- RESP, lasting exactly 1 cycle:
  - Pulse if_valid or d_valid, plus err if aborted.
  - mem_req=0, return to IDLE.
- Latency: request seen in IDLE at cycle N; mem_req high from N+1; mem_ready at cycle M; valid at M+1. Minimum request-to-valid latency is 3 cycles (IDLE, GNT, RESP).
- mem_req/mem_we are registered (no combinational path from if_req/d_* to mem_*).
- stall = (if_req & ~if_valid) | (d_req & ~d_valid). This is the only combinational output.
- Request dropped while granted (protocol violation): the transfer still completes and the valid pulse is issued. Not an error.
- mem_ready in IDLE or RESP is ignored.
- Reset mid-transfer: mem_req drops immediately (asynchronously). No valid is issued for the in-flight transfer.

Test Plan:
1. Single fetch: if_req=1, if_addr=0x100; mem_ready asserted 2 cycles after mem_req with mem_rdata=0x00500093. Expect mem_req/mem_addr=0x100/mem_we=0, then if_valid for 1 cycle with if_rdata=0x00500093, err=0, and stall high until that valid.
2. Store: d_wr=1, d_addr=0x2000, d_wdata=0xDEADBEEF, mem_ready=1 immediately. Expect mem_we=1 and mem_wdata=0xDEADBEEF for exactly one mem_req cycle, then d_valid 3 cycles after the request.
3. Contention: if_req and d_rd held together for 4 transfers, each mem_ready 1 cycle late. Expect grant order I, D, I, D, with no back-to-back same-side grant while the other side waits.
4. Timeout with TIMEOUT=16: d_rd=1, mem_ready held 0. Expect mem_req high for exactly 16 cycles, then d_valid=1, err=1, d_rdata=0, then IDLE.
5. Async reset: assert rst_n=0 mid-GNT_D. Expect mem_req=0 with no clock edge; after release, first contended grant goes to fetch.
6. Protocol robustness: d_rd and d_wr both high → store performed. mem_ready pulsed while IDLE → no valid, no state change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Each transfer runs IDLE -> GNT -> RESP; hung accesses abort after TIMEOUT cycles with err.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_valid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_rd,
   input  logic          d_wr,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_valid,
   output logic [DW-1:0] d_rdata,
   output logic          err,
   output logic          stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ready,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

   state_t        state;
   logic          last_d;
   logic [TW-1:0] timer;
   logic          d_req;
   logic          grant_i;
   logic          grant_d;
   logic          done;
   logic          abort;

   assign d_req   = d_rd | d_wr;
   // On contention fetch wins only when data was served last.
   assign grant_i = if_req & (~d_req | last_d);
   assign grant_d = d_req & ~grant_i;
   assign done    = mem_ready;
   assign abort   = ~mem_ready & (timer == TMAX);

   assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last_d    <= 1'b1;
         timer     <= '0;
         if_valid  <= 1'b0;
         d_valid   <= 1'b0;
         err       <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         err      <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_i) begin
                  state     <= GNT_I;
                  last_d    <= 1'b0;
                  timer     <= '0;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
               end else if (grant_d) begin
                  state     <= GNT_D;
                  last_d    <= 1'b1;
                  timer     <= '0;
                  mem_req   <= 1'b1;
                  mem_we    <= d_wr;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
               end
            end
            GNT_I, GNT_D: begin
               if (done || abort) begin
                  state   <= RESP;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  err     <= ~done;
                  // An aborted access returns zero data rather than whatever is on the bus.
                  if (state == GNT_I) begin
                     if_valid <= 1'b1;
                     if_rdata <= done ? mem_rdata : '0;
                  end else begin
                     d_valid <= 1'b1;
                     d_rdata <= done ? mem_rdata : '0;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
